// File: rtl/ring_mem_responder_if.sv
// Ring flit types and the ring port interface for ring_mem_responder.
// One instance per ring direction: master drives a ring, slave receives it.
package ring_mem_responder_pkg;

  typedef enum logic [1:0] {
    RD     = 2'b00,
    RD_RSP = 2'b01,
    WR     = 2'b10,
    WR_RSP = 2'b11
  } t_opcode;

  typedef struct packed {
    logic        valid;
    logic [9:0]  requestor;
    t_opcode     opcode;
    logic [31:0] address;
    logic [31:0] data;
  } t_ring_flit;

endpackage

interface ring_mem_responder_if;
  import ring_mem_responder_pkg::*;

  logic        valid;
  logic [9:0]  requestor;
  t_opcode     opcode;
  logic [31:0] address;
  logic [31:0] data;

  modport master (
    output valid, requestor, opcode,
    output address, data
  );

  modport slave (
    input valid, requestor, opcode,
    input address, data
  );

endinterface

// File: rtl/ring_mem_responder.sv
// Ring target: serves RD/WR requests to this tile from a local word memory,
// forwards foreign traffic Q500->Q502, injects responses into idle rsp slots.
// Ports: QClk, RstQnnnL, CoreID, req_in/rsp_in (slave), req_out/rsp_out
// (master), RspFifoCount (response FIFO occupancy).
module ring_mem_responder
  import ring_mem_responder_pkg::*;
#(
  parameter int MEM_WORDS  = 256,
  parameter int FIFO_DEPTH = 4,
  localparam int AW = $clog2(MEM_WORDS),
  localparam int PW = $clog2(FIFO_DEPTH),
  localparam int CW = PW + 1
) (
  input  logic                  QClk,
  input  logic                  RstQnnnL,
  input  logic [7:0]            CoreID,
  ring_mem_responder_if.slave   req_in,
  ring_mem_responder_if.slave   rsp_in,
  ring_mem_responder_if.master  req_out,
  ring_mem_responder_if.master  rsp_out,
  output logic [CW-1:0]         RspFifoCount
);

  t_ring_flit req_in_f;
  t_ring_flit rsp_in_f;
  t_ring_flit req_q1;
  t_ring_flit rsp_q1;
  t_ring_flit req_q2;
  t_ring_flit rsp_q2;
  t_ring_flit req_nxt;
  t_ring_flit rsp_nxt;
  t_ring_flit push_f;

  logic [31:0]   mem [MEM_WORDS];
  t_ring_flit    fifo_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  logic [AW-1:0] idx;
  logic [31:0]   rd_data;
  logic          is_req;
  logic          is_wr;
  logic          hit;
  logic          pop;

  assign req_in_f = {
    req_in.valid, req_in.requestor,
    req_in.opcode, req_in.address,
    req_in.data
  };

  assign rsp_in_f = {
    rsp_in.valid, rsp_in.requestor,
    rsp_in.opcode, rsp_in.address,
    rsp_in.data
  };

  always_ff @(posedge QClk or negedge RstQnnnL) begin
    if (!RstQnnnL) begin
      req_q1 <= '0;
      rsp_q1 <= '0;
      req_q2 <= '0;
      rsp_q2 <= '0;
    end else begin
      req_q1 <= req_in_f;
      rsp_q1 <= rsp_in_f;
      req_q2 <= req_nxt;
      rsp_q2 <= rsp_nxt;
    end
  end

  assign idx    = req_q1.address[AW+1:2];
  assign is_wr  = req_q1.opcode == WR;
  assign is_req = is_wr || (req_q1.opcode == RD);

  // Full FIFO refuses the hit even if a pop frees a slot this cycle.
  assign hit = req_q1.valid && is_req
            && (req_q1.address[31:24] == CoreID)
            && (RspFifoCount < CW'(FIFO_DEPTH));

  // Foreign responses own the slot; we only fill idle ones.
  assign pop = !rsp_q1.valid && (RspFifoCount != '0);

  always_ff @(posedge QClk) begin
    if (hit && is_wr) begin
      mem[idx] <= req_q1.data;
    end
  end

  assign rd_data = mem[idx];

  always_comb begin
    push_f        = req_q1;
    push_f.valid  = 1'b1;
    push_f.opcode = is_wr ? WR_RSP : RD_RSP;
    push_f.data   = is_wr ? req_q1.data : rd_data;
  end

  always_ff @(posedge QClk) begin
    if (hit) begin
      fifo_q[wr_ptr] <= push_f;
    end
  end

  always_ff @(posedge QClk or negedge RstQnnnL) begin
    if (!RstQnnnL) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      RspFifoCount <= '0;
    end else begin
      if (hit) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      unique case (1'b1)
        hit && !pop: RspFifoCount <= RspFifoCount + CW'(1);
        pop && !hit: RspFifoCount <= RspFifoCount - CW'(1);
        default:     RspFifoCount <= RspFifoCount;
      endcase
    end
  end

  always_comb begin
    req_nxt = hit ? '0 : req_q1;
    rsp_nxt = pop ? fifo_q[rd_ptr] : rsp_q1;
  end

  assign req_out.valid     = req_q2.valid;
  assign req_out.requestor = req_q2.requestor;
  assign req_out.opcode    = req_q2.opcode;
  assign req_out.address   = req_q2.address;
  assign req_out.data      = req_q2.data;

  assign rsp_out.valid     = rsp_q2.valid;
  assign rsp_out.requestor = rsp_q2.requestor;
  assign rsp_out.opcode    = rsp_q2.opcode;
  assign rsp_out.address   = rsp_q2.address;
  assign rsp_out.data      = rsp_q2.data;

endmodule

// File: tb/tb_ring_mem_responder.sv
// Testbench for ring_mem_responder: directed scenarios plus random traffic
// checked against a queue/array model of the ring agent.
module tb_ring_mem_responder;
  import ring_mem_responder_pkg::*;

  localparam int FD = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] core_id = 8'd3;
  logic [2:0] cnt;

  ring_mem_responder_if req_in_if ();
  ring_mem_responder_if rsp_in_if ();
  ring_mem_responder_if req_out_if ();
  ring_mem_responder_if rsp_out_if ();

  ring_mem_responder #(
    .MEM_WORDS  (256),
    .FIFO_DEPTH (FD)
  ) dut (
    .QClk         (clk),
    .RstQnnnL     (rst_n),
    .CoreID       (core_id),
    .req_in       (req_in_if),
    .rsp_in       (rsp_in_if),
    .req_out      (req_out_if),
    .rsp_out      (rsp_out_if),
    .RspFifoCount (cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    t_ring_flit f;
    bit         dk;
  } t_ent;

  int          n_tests = 0;
  int          n_fail  = 0;
  t_ent        mq[$];
  logic [31:0] mmem [int];
  t_ring_flit  s1q, s1r, e_req;
  t_ent        e_rsp;
  t_ring_flit  idle_f;

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic t_ring_flit flit(
    input bit v, input logic [9:0] r, input t_opcode o,
    input logic [31:0] a, input logic [31:0] d);
    t_ring_flit f;
    f.valid = v; f.requestor = r; f.opcode = o;
    f.address = a; f.data = d;
    return f;
  endfunction

  function automatic t_ring_flit get_req();
    return flit(req_out_if.valid, req_out_if.requestor,
                req_out_if.opcode, req_out_if.address,
                req_out_if.data);
  endfunction

  function automatic t_ring_flit get_rsp();
    return flit(rsp_out_if.valid, rsp_out_if.requestor,
                rsp_out_if.opcode, rsp_out_if.address,
                rsp_out_if.data);
  endfunction

  task automatic drive(input t_ring_flit rq, input t_ring_flit rs);
    req_in_if.valid     = rq.valid;
    req_in_if.requestor = rq.requestor;
    req_in_if.opcode    = rq.opcode;
    req_in_if.address   = rq.address;
    req_in_if.data      = rq.data;
    rsp_in_if.valid     = rs.valid;
    rsp_in_if.requestor = rs.requestor;
    rsp_in_if.opcode    = rs.opcode;
    rsp_in_if.address   = rs.address;
    rsp_in_if.data      = rs.data;
  endtask

  task automatic model_clear();
    mq.delete();
    s1q = '0; s1r = '0; e_req = '0;
    e_rsp.f = '0; e_rsp.dk = 1'b1;
  endtask

  // One clock: drive inputs, advance the model, check outputs after the edge.
  task automatic step(input t_ring_flit rq, input t_ring_flit rs);
    t_ent       pe;
    bit         hit;
    int         idx;
    t_ring_flit g;
    drive(rq, rs);
    if (rst_n) begin
      hit = s1q.valid && (s1q.opcode == RD || s1q.opcode == WR)
         && s1q.address[31:24] == core_id && mq.size() < FD;
      e_req = hit ? '0 : s1q;
      if (s1r.valid || mq.size() == 0) begin
        e_rsp.f = s1r; e_rsp.dk = 1'b1;
      end else begin
        e_rsp = mq.pop_front();
      end
      if (hit) begin
        idx = int'(s1q.address[9:2]);
        pe.f = s1q;
        pe.f.valid = 1'b1;
        if (s1q.opcode == WR) begin
          mmem[idx] = s1q.data;
          pe.f.opcode = WR_RSP;
          pe.dk = 1'b1;
        end else begin
          pe.f.opcode = RD_RSP;
          pe.dk = mmem.exists(idx);
          pe.f.data = pe.dk ? mmem[idx] : 32'h0;
        end
        mq.push_back(pe);
      end
      s1q = rq; s1r = rs;
    end else begin
      model_clear();
    end
    @(posedge clk);
    @(negedge clk);
    chk("req_out", get_req(), e_req);
    g = get_rsp();
    chk("rsp_hdr", g[76:32], e_rsp.f[76:32]);
    if (e_rsp.dk) chk("rsp_data", g.data, e_rsp.f.data);
    chk("count", cnt, mq.size());
  endtask

  function automatic t_ring_flit rnd_req();
    logic [7:0] c;
    c = ($urandom_range(0, 3) != 0) ? core_id : 8'($urandom);
    return flit($urandom_range(0, 9) < 6, 10'($urandom),
                t_opcode'($urandom_range(0, 3)),
                {c, 14'($urandom), 4'b0, 4'($urandom), 2'($urandom)},
                $urandom);
  endfunction

  function automatic t_ring_flit rnd_rsp();
    return flit($urandom_range(0, 9) < 3, 10'($urandom),
                $urandom_range(0, 1) ? RD_RSP : WR_RSP,
                $urandom, $urandom);
  endfunction

  t_ring_flit pt, wrf, rdf, nrf;

  initial begin
    idle_f = '0;
    model_clear();
    drive(idle_f, idle_f);
    @(negedge clk);
    step(idle_f, idle_f);
    step(idle_f, idle_f);
    rst_n = 1'b1;

    // pass-through to a foreign tile
    pt = flit(1, 10'h011, WR, 32'h0500_0020, 32'h1234_5678);
    step(pt, idle_f);
    step(idle_f, idle_f);
    chk("pt_req", get_req(), pt);
    chk("pt_rsp_idle", rsp_out_if.valid, 1'b0);
    step(idle_f, idle_f);

    // write then read back
    wrf = flit(1, 10'h041, WR, 32'h0300_0010, 32'hDEAD_BEEF);
    step(wrf, idle_f);
    step(idle_f, idle_f);
    chk("wr_bubble", get_req(), 77'h0);
    step(idle_f, idle_f);
    chk("wr_rsp", get_rsp(),
        flit(1, 10'h041, WR_RSP, 32'h0300_0010, 32'hDEAD_BEEF));
    rdf = flit(1, 10'h041, RD, 32'h0300_0010, 32'h0);
    step(rdf, idle_f);
    step(idle_f, idle_f);
    step(idle_f, idle_f);
    chk("rd_rsp", get_rsp(),
        flit(1, 10'h041, RD_RSP, 32'h0300_0010, 32'hDEAD_BEEF));

    // response opcode on the request ring is not served
    nrf = flit(1, 10'h055, RD_RSP, 32'h0300_0010, 32'h0000_CAFE);
    step(nrf, idle_f);
    step(idle_f, idle_f);
    chk("nreq_fwd", get_req(), nrf);
    step(rdf, idle_f);
    step(idle_f, idle_f);
    step(idle_f, idle_f);
    chk("nreq_mem", rsp_out_if.data, 32'hDEAD_BEEF);

    // full FIFO under busy response ring
    for (int i = 0; i < 10; i++) begin
      step(i < 5 ? flit(1, 10'h200 + 10'(i), RD,
                        32'h0300_0000 + 32'(4 * i), 32'h0)
                 : idle_f,
           flit(1, 10'h100 + 10'(i), RD_RSP, 32'h0900_0000, 32'(i)));
      if (i == 4) chk("full_cnt", cnt, 3'd4);
      if (i == 5)
        chk("full_pass", get_req(),
            flit(1, 10'h204, RD, 32'h0300_0010, 32'h0));
    end
    for (int i = 0; i < 8; i++) step(idle_f, idle_f);
    chk("drain_cnt", cnt, 3'd0);

    // push and pop in the same cycle at count 2
    for (int i = 0; i < 5; i++) begin
      step((i == 0 || i == 1 || i == 3)
             ? flit(1, 10'h300 + 10'(i), WR,
                    32'h0300_0020 + 32'(4 * i), 32'hA000 + 32'(i))
             : idle_f,
           (i < 3) ? flit(1, 10'h0AA, WR_RSP, 32'h0800_0000, 32'h0)
                   : idle_f);
      if (i == 2) chk("pp_cnt2", cnt, 3'd2);
      if (i == 4) chk("pp_hold", cnt, 3'd2);
    end
    for (int i = 0; i < 6; i++) step(idle_f, idle_f);

    // random traffic, then asynchronous reset mid-flight
    for (int i = 0; i < 40; i++) step(rnd_req(), rnd_rsp());
    #2 rst_n = 1'b0;
    #1;
    chk("rst_req", get_req(), 77'h0);
    chk("rst_rsp", get_rsp(), 77'h0);
    chk("rst_cnt", cnt, 3'd0);
    model_clear();
    step(rnd_req(), rnd_rsp());
    step(rnd_req(), rnd_rsp());
    rst_n = 1'b1;

    for (int i = 0; i < 400; i++) step(rnd_req(), rnd_rsp());
    for (int i = 0; i < 10; i++) step(idle_f, idle_f);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
